imem_loader: RTL and testbench

//  Boot-time writer for the CPU instruction memory. Consumes a framed byte stream

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader that writes a framed UART byte stream into instruction RAM
//
// Purpose:
//   Receives SYNC, CNT_LO, CNT_HI, then CNT little-endian 32-bit words (and an
//   optional CHK byte). Each word is written through the instruction RAM write
//   port. The CPU is held in reset until the whole image has been accepted.
//
// Optional feature:
//   LOADER_CHECKSUM_EN  when defined, a trailing CHK byte (XOR of all data bytes)
//                       must match for the image to be accepted.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx_data     received byte, qualified by rx_valid
//   rx_valid    one-cycle strobe per received byte
//   we          instruction RAM write enable, one-cycle pulse per word
//   waddr       word-aligned byte address of the word being written
//   wdata       instruction word {b3,b2,b1,b0}, b0 received first
//   cpu_hold    1 keeps the CPU in reset
//   load_done   image complete and accepted (level)
//   load_error  frame rejected (level)
module imem_loader #(
    parameter int          ADDR_W = 12,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_LO = 3'd1;
    localparam logic [2:0] ST_CNT_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHK    = 3'd6;
    // State entered once all words (possibly none) have been received.
    localparam logic [2:0] ST_AFTER  = ST_CHK;
`else
    localparam logic [2:0] ST_AFTER  = ST_DONE;
`endif

    // Largest legal word count; compared in 17 bits so 2**ADDR_W itself is representable.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]        state;
    logic [15:0]       cnt;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       wbuf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk;
`endif

    logic              sync_hit;
    logic [16:0]       cnt_full;
    logic [ADDR_W:0]   idx_next;
    logic              last_word;

    assign sync_hit  = rx_valid && (rx_data == SYNC);
    assign cnt_full  = {1'b0, rx_data, cnt[7:0]};
    assign idx_next  = word_idx + (ADDR_W+1)'(1);
    assign last_word = (17'(idx_next) == {1'b0, cnt});

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            we         <= 1'b0;
            waddr      <= 32'd0;
            wdata      <= 32'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cnt        <= 16'd0;
            word_idx   <= '0;
            byte_idx   <= 2'd0;
            wbuf       <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            chk        <= 8'd0;
`endif
        end else begin
            we <= 1'b0;
            // Status outputs follow the state one cycle late, so the release of
            // cpu_hold always lands after the final write pulse. A SYNC byte in
            // DONE/ERR re-asserts hold and clears the status in the same edge.
            cpu_hold   <= !((state == ST_DONE) && !sync_hit);
            load_done  <= (state == ST_DONE) && !sync_hit;
            load_error <= (state == ST_ERR) && !sync_hit;

            if (rx_valid) begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (sync_hit) begin
                            state <= ST_CNT_LO;
                        end
                    end
                    ST_CNT_LO: begin
                        cnt[7:0] <= rx_data;
                        word_idx <= '0;
                        byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        chk      <= 8'd0;
`endif
                        state    <= ST_CNT_HI;
                    end
                    ST_CNT_HI: begin
                        cnt[15:8] <= rx_data;
                        if (cnt_full == 17'd0) begin
                            state <= ST_AFTER;
                        end else if (cnt_full > MAX_WORDS) begin
                            state <= ST_ERR;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        chk <= chk ^ rx_data;
`endif
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: wbuf[7:0]   <= rx_data;
                            2'd1: wbuf[15:8]  <= rx_data;
                            2'd2: wbuf[23:16] <= rx_data;
                            default: begin
                                we       <= 1'b1;
                                wdata    <= {rx_data, wbuf};
                                waddr    <= 32'({word_idx, 2'b00});
                                word_idx <= idx_next;
                                if (last_word) begin
                                    state <= ST_AFTER;
                                end
                            end
                        endcase
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        state <= (rx_data == chk) ? ST_DONE : ST_ERR;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a write scoreboard
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;
    int nwr    = 0;
    int base;
    logic        prev_we = 1'b0;
    logic [63:0] sb[$];
    logic [63:0] ent;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write pulse is matched against the next expected {addr,data}.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            nwr++;
            check("we_while_hold", 32'(cpu_hold), 32'd1);
            check("we_single_cycle", 32'(prev_we), 32'd0);
            check("we_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                ent = sb.pop_front();
                check("waddr", waddr, ent[63:32]);
                check("wdata", wdata, ent[31:0]);
            end
        end
        prev_we = we;
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Presents one byte for one cycle; consecutive calls give back-to-back strobes.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
        sb.push_back({addr, w});
        for (int k = 0; k < 4; k++) begin
            send(w[8*k +: 8]);
            if (gap) idle(1);
        end
    endtask

    task automatic header(input logic [15:0] n);
        send(8'hA5);
        send(n[7:0]);
        send(n[15:8]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", waddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);

        // Two-word frame with gaps; hold releases the cycle after the second write.
        header(16'd2);
        send_word(32'h00100013, 32'd0, 1'b1);
        sb.push_back({32'd4, 32'h00200093});
        send(8'h93); idle(1); send(8'h00); idle(1); send(8'h20); idle(1);
        send(8'h00);
        check("t1_we_cycle", 32'(we), 32'd1);
        check("t1_hold_in_we", 32'(cpu_hold), 32'd1);
        idle(1);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_load_done", 32'(load_done), 32'd1);
        check("t1_writes", 32'(nwr), 32'd2);

        // Leading junk is discarded in IDLE.
        do_reset();
        base = nwr;
        send(8'h00); send(8'hFF);
        header(16'd1);
        send_word(32'hDEADBEEF, 32'd0, 1'b0);
        idle(2);
        check("t2_writes", 32'(nwr - base), 32'd1);
        check("t2_done", 32'(load_done), 32'd1);

        // Restart from DONE, back-to-back bytes for three words.
        base = nwr;
        header(16'd3);
        check("t3_hold_restart", 32'(cpu_hold), 32'd1);
        check("t3_done_cleared", 32'(load_done), 32'd0);
        send_word(32'h11223344, 32'd0, 1'b0);
        send_word(32'h55667788, 32'd4, 1'b0);
        send_word(32'h99AABBCC, 32'd8, 1'b0);
        idle(2);
        check("t3_writes", 32'(nwr - base), 32'd3);
        check("t3_done", 32'(load_done), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd0);

        // Oversized count is rejected; a valid frame recovers.
        base = nwr;
        header(16'h2001);
        idle(2);
        check("t4_error", 32'(load_error), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd1);
        check("t4_done", 32'(load_done), 32'd0);
        header(16'h1001);
        idle(2);
        check("t4_error_edge", 32'(load_error), 32'd1);
        header(16'd1);
        idle(1);
        check("t4_error_cleared", 32'(load_error), 32'd0);
        send_word(32'hCAFEF00D, 32'd0, 1'b0);
        idle(2);
        check("t4_writes", 32'(nwr - base), 32'd1);
        check("t4_done", 32'(load_done), 32'd1);
        check("t4_error_low", 32'(load_error), 32'd0);

        // Zero-length frame completes with no writes.
        base = nwr;
        header(16'd0);
        idle(2);
        check("t0_done", 32'(load_done), 32'd1);
        check("t0_hold", 32'(cpu_hold), 32'd0);
        check("t0_writes", 32'(nwr - base), 32'd0);

        // Reset in the middle of word 1 discards it; re-sent frame completes.
        base = nwr;
        header(16'd2);
        send_word(32'h0A0B0C0D, 32'd0, 1'b0);
        send(8'h01); send(8'h02);
        do_reset();
        idle(1);
        check("t5_writes", 32'(nwr - base), 32'd1);
        check("t5_hold", 32'(cpu_hold), 32'd1);
        check("t5_done", 32'(load_done), 32'd0);
        send(8'h03); send(8'h04);
        idle(2);
        check("t5_idle_ignores", 32'(nwr - base), 32'd1);
        header(16'd2);
        send_word(32'h0A0B0C0D, 32'd0, 1'b0);
        send_word(32'h04030201, 32'd4, 1'b0);
        idle(2);
        check("t5_rewrites", 32'(nwr - base), 32'd3);
        check("t5_done_final", 32'(load_done), 32'd1);

        // Full-capacity frame: cnt == 2**12 writes up to the last word.
        base = nwr;
        header(16'h1000);
        for (int i = 0; i < 4096; i++) begin
            send_word(32'(i) * 32'h9E3779B1, 32'(i) * 32'd4, 1'b0);
        end
        idle(2);
        check("full_writes", 32'(nwr - base), 32'd4096);
        check("full_done", 32'(load_done), 32'd1);
        check("full_error", 32'(load_error), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
